// File: rtl/imm_gen_pipe_if.sv
// Handshake and data bundle between the immediate generator and its producer/consumer.
// The master drives the input side and the output ready; the slave is the generator.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned ERR_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      imm;
    logic [2:0]       ImmSrc;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, imm, ImmSrc, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal, err_cnt
    );

    modport slave (
        input  in_valid, imm, ImmSrc, in_tag, flush, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal, err_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes instr[31:7] into an XLEN immediate and passes it
// through PIPE_DEPTH elastic register stages with a combinational ready chain.
module imm_gen_pipe #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PIPE_DEPTH = 1,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned ERR_W      = 8
) (
    input logic             clk,
    input logic             rst_n,
    imm_gen_pipe_if.slave   bus_io
);

    logic signed [31:0] dec_raw;
    logic [XLEN-1:0]    dec_imm;
    logic               dec_illegal;
    logic [ERR_W-1:0]   err_q, err_d;

    // Every format fits a sign-correct 32-bit value; the final cast widens it for XLEN=64.
    always_comb begin
        dec_raw     = '0;
        dec_illegal = 1'b0;
        unique case (bus_io.ImmSrc)
            3'b000: dec_raw = {{20{bus_io.imm[24]}}, bus_io.imm[24:13]};
            3'b001: dec_raw = {{20{bus_io.imm[24]}}, bus_io.imm[24:18], bus_io.imm[4:0]};
            3'b101: dec_raw = {{19{bus_io.imm[24]}}, bus_io.imm[24], bus_io.imm[0],
                               bus_io.imm[23:18], bus_io.imm[4:1], 1'b0};
            3'b010: dec_raw = {bus_io.imm[24:5], 12'b0};
            3'b110: dec_raw = {{11{bus_io.imm[24]}}, bus_io.imm[24], bus_io.imm[12:5],
                               bus_io.imm[13], bus_io.imm[23:14], 1'b0};
            3'b011: dec_raw = {27'b0, bus_io.imm[12:8]};
            3'b100: dec_raw = {20'b0, bus_io.imm[24:13]};
            3'b111: dec_illegal = 1'b1;
            default: dec_raw = '0;
        endcase
    end

    assign dec_imm = XLEN'(dec_raw);

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        logic             valid_q, valid_d, ill_q, ill_d, load;
        logic [XLEN-1:0]  imm_q, imm_d;
        logic [TAG_W-1:0] tag_q, tag_d;
        logic             src_valid, src_ill;
        logic [XLEN-1:0]  src_imm;
        logic [TAG_W-1:0] src_tag;

        if (k == PIPE_DEPTH - 1) begin : g_tail
            assign load = !valid_q || bus_io.out_ready;
        end else begin : g_mid
            assign load = !valid_q || g_stage[k+1].load;
        end

        if (k == 0) begin : g_head
            assign src_valid = bus_io.in_valid;
            assign src_imm   = dec_imm;
            assign src_tag   = bus_io.in_tag;
            assign src_ill   = dec_illegal;
        end else begin : g_body
            assign src_valid = g_stage[k-1].valid_q;
            assign src_imm   = g_stage[k-1].imm_q;
            assign src_tag   = g_stage[k-1].tag_q;
            assign src_ill   = g_stage[k-1].ill_q;
        end

        always_comb begin
            valid_d = valid_q;
            imm_d   = imm_q;
            tag_d   = tag_q;
            ill_d   = ill_q;
            if (load) begin
                valid_d = src_valid;
                if (src_valid) begin
                    imm_d = src_imm;
                    tag_d = src_tag;
                    ill_d = src_ill;
                end
            end
            if (bus_io.flush) valid_d = 1'b0;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                imm_q   <= '0;
                tag_q   <= '0;
                ill_q   <= 1'b0;
            end else begin
                valid_q <= valid_d;
                imm_q   <= imm_d;
                tag_q   <= tag_d;
                ill_q   <= ill_d;
            end
        end
    end

    // Only illegal entries that actually enter the pipe (and survive a flush) are counted.
    always_comb begin
        err_d = err_q;
        if (bus_io.in_valid && g_stage[0].load && !bus_io.flush && dec_illegal &&
            err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end

    assign bus_io.in_ready    = g_stage[0].load;
    assign bus_io.out_valid   = g_stage[PIPE_DEPTH-1].valid_q;
    assign bus_io.out_imm     = g_stage[PIPE_DEPTH-1].imm_q;
    assign bus_io.out_tag     = g_stage[PIPE_DEPTH-1].tag_q;
    assign bus_io.out_illegal = g_stage[PIPE_DEPTH-1].ill_q;
    assign bus_io.err_cnt     = err_q;

endmodule
